sync_link_tx: RTL and testbench
===============================

Name: sync_link_tx

Overview:
- Clocked-to-asynchronous bridge that sits directly upstream of the dual-rail memory register stage.
- Accepts binary words on a synchronous valid/ready interface.
- Encodes each word as a dual-rail codeword and drives it onto a link_intf.out port using four-phase return-to-zero signalling.
- Sequences the protocol from the link's synchronised acknowledge: one word per token.

Parameters:
- REG_WIDTH, 2, number of logical bits per token; link data width is 2*REG_WIDTH.
- SYNC_STAGES, 2, flip-flop depth of the out.ack synchroniser; legal range 2..4.
- TIMEOUT_CYCLES, 1024, ack-wait limit in clk cycles; used only with the optional feature.

Ports:
- clk, input, 1, single clock for all sequential logic.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, REG_WIDTH, binary word to send.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, bridge can accept a word this cycle.
- out, link_intf.out, data 2*REG_WIDTH plus ack 1: out.data is driven (dual-rail codeword/spacer); out.ack is received (asynchronous acknowledge from downstream).
- busy, output, 1, a token is in flight (state is not IDLE).

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Encoding: bit i maps to rails out.data[2i+1:2i]:
  - 2'b01 is logic 0; 2'b10 is logic 1; 2'b00 is spacer.
  - 2'b11 is never driven.
- Glitch-free output: out.data comes straight from flops, with no combinational logic after the registers.
- Ack synchroniser: out.ack passes through SYNC_STAGES flops, all reset to 0; the last stage output is ack_s.
- FSM states:
  - IDLE: spacer on out.data. in_ready = !ack_s. On in_valid && in_ready, register the encoded in_data into out.data and go to EVAL.
  - EVAL: hold the codeword; in_ready=0. When ack_s==1, drive spacer and go to NULL.
  - NULL: hold spacer; in_ready=0. When ack_s==0, go to IDLE.
- Handshake: in_data is sampled only on the edge where in_valid && in_ready. in_data may change freely otherwise. in_valid may drop while in_ready=0 without side effects.
- Latency, accept to link:
  - Codeword visible immediately after the accepting edge.
  - Spacer visible SYNC_STAGES+1 edges after out.ack rises (ack quasi-synchronous to clk).
  - IDLE re-entered SYNC_STAGES+1 edges after out.ack falls.
- Throughput with zero-delay downstream: one token per 2*SYNC_STAGES+3 cycles (7 for the default).
- busy = (state != IDLE).
- Reset values: state IDLE; out.data all 0 (spacer); busy=0; synchroniser flops 0; in_ready=1 after reset deasserts, provided ack_s is 0.
- Reset mid-token: out.data returns to spacer asynchronously and any captured word is discarded. Downstream shares rst, so both ends restart clean.
- Ack already high in IDLE (e.g. stale after reset): in_ready stays 0 until ack_s falls. A new codeword is never driven over a high ack.
- Ack glitches are tolerated. EVAL ignores ack_s==0 and NULL ignores ack_s==1; no state is skipped.
- in_valid asserted in the cycle the FSM enters IDLE is accepted in that cycle, since in_ready is combinational from state and ack_s.

Optional Feature:
- Macro: SYNC_LINK_TX_ACK_TIMEOUT_EN.
- When defined:
  - Adds output ack_err (1 bit) and a ceil(log2(TIMEOUT_CYCLES+1))-bit wait counter.
  - The counter clears on every state change and counts cycles spent in EVAL or NULL.
  - When it reaches TIMEOUT_CYCLES, ack_err sets and stays set until rst.
  - The FSM keeps waiting; it never aborts a token, because aborting would break four-phase order.
  - ack_err resets to 0.
- When undefined: no ack_err port, no counter; behaviour otherwise identical.

Test Plan:
- Reset: assert rst mid-cycle -> out.data=4'b0000, busy=0 immediately; after release with out.ack=0, in_ready=1 by the first edge.
- Single token (REG_WIDTH=2): in_data=2'b10 accepted -> out.data=4'b1001. Ack raised at once -> spacer 3 edges later. Ack dropped -> in_ready=1 3 edges later.
- Back-to-back: in_valid held high with words 2'b00, 2'b11, 2'b01 and a zero-delay ack model -> codewords 4'b0101, 4'b1010, 4'b0110 in order, each separated by spacer, 7 cycles per token; no word lost or duplicated.
- Stale ack: out.ack=1 at reset release -> in_ready=0 and out.data stays spacer until ack drops, then in_ready=1 after 2 edges.
- Reset during EVAL: rst pulse while codeword 4'b1001 is held -> out.data=4'b0000 asynchronously; after release the next accepted word is sent normally.
- With SYNC_LINK_TX_ACK_TIMEOUT_EN and TIMEOUT_CYCLES=16: ack withheld after accept -> ack_err=1 after 16 cycles in EVAL. Late ack still completes the token; ack_err stays 1 until rst.

Source files
------------

// File: rtl/sync_link_tx_if.sv
// link_intf: dual-rail four-phase link between a clocked sender and an
// asynchronous receiver. data carries one dual-rail codeword or spacer,
// ack is the receiver's return-to-zero acknowledge.
interface link_intf #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;
    logic             ack;

    // Sender side: drives the rails, listens to the acknowledge
    modport out (output data, input ack);

    // Receiver side: listens to the rails, drives the acknowledge
    modport in (input data, output ack);
endinterface

// File: rtl/sync_link_tx.sv
// sync_link_tx: valid/ready to dual-rail four-phase bridge.
// Each accepted word is held as a dual-rail codeword until the synchronised
// ack rises, then replaced by spacer until the ack falls again.
// Optional build macro SYNC_LINK_TX_ACK_TIMEOUT_EN adds a sticky ack_err
// output flagging a token that waited TIMEOUT_CYCLES clocks in one phase.
module sync_link_tx #(
    parameter int REG_WIDTH      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    link_intf.out                out,
`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
    output logic                 ack_err,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_NULL = 2'd2
    } stateT;

    stateT                    r_state;
    stateT                    w_nextState;
    logic [SYNC_STAGES-1:0]   r_ackSync;
    logic                     w_ackS;
    logic                     w_accept;
    logic [2*REG_WIDTH-1:0]   r_data;
    logic [2*REG_WIDTH-1:0]   w_dataNext;

    // Reject parameter values the synchroniser and timeout cannot support
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
        $error("sync_link_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    // Bit i becomes rails {1,0} for a one and {0,1} for a zero
    function automatic logic [2*REG_WIDTH-1:0] encodeDualRail(input logic [REG_WIDTH-1:0] word);
        logic [2*REG_WIDTH-1:0] code;
        code = '0;
        for (int i = 0; i < REG_WIDTH; i++) begin
            code[2*i +: 2] = word[i] ? 2'b10 : 2'b01;
        end
        return code;
    endfunction

    // Bring the asynchronous acknowledge into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ackSync <= '0;
        end else begin
            r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], out.ack};
        end
    end

    assign w_ackS = r_ackSync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: each phase waits only for the ack level that ends it, so
    // glitches toward the other level are ignored and no phase is skipped
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = ST_EVAL;
            ST_EVAL: if (w_ackS)   w_nextState = ST_NULL;
            ST_NULL: if (!w_ackS)  w_nextState = ST_IDLE;
            default:               w_nextState = ST_IDLE;
        endcase
    end

    // Outputs: handshake is combinational, rail contents are computed here and
    // registered below so the link itself only ever sees flop outputs
    always_comb begin
        in_ready   = (r_state == ST_IDLE) && !w_ackS;
        busy       = (r_state != ST_IDLE);
        w_accept   = in_valid && in_ready;
        w_dataNext = r_data;
        case (r_state)
            ST_IDLE: if (w_accept) w_dataNext = encodeDualRail(in_data);
            ST_EVAL: if (w_ackS)   w_dataNext = '0;
            default:               w_dataNext = '0;
        endcase
    end

    // Rail register; reset forces spacer immediately and drops any held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_dataNext;
        end
    end

    assign out.data = r_data;

`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_ackErr;

    // Wait counter restarts on each phase change and saturates at the limit
    always_comb begin
        w_cntNext = '0;
        if (w_nextState == r_state && r_state != ST_IDLE) begin
            w_cntNext = (r_waitCnt == CNT_MAX) ? r_waitCnt : r_waitCnt + 1'b1;
        end
    end

    // Sticky error; the token is never aborted so four-phase order survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= '0;
            r_ackErr  <= 1'b0;
        end else begin
            r_waitCnt <= w_cntNext;
            r_ackErr  <= r_ackErr | (w_cntNext == CNT_MAX);
        end
    end

    assign ack_err = r_ackErr;
`endif

endmodule

// File: tb/tb_sync_link_tx.sv
// tb_sync_link_tx: directed bench for sync_link_tx with a token-level
// reference model, a per-cycle compare process and an in-order scoreboard.
// Build with SYNC_LINK_TX_ACK_TIMEOUT_EN to also exercise ack_err.
module tb_sync_link_tx;

    localparam int REG_WIDTH      = 2;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int DW             = 2 * REG_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [REG_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 busy;
`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
    logic                 ack_err;
`endif
    logic                 ackManual;
    logic                 autoAck;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    link_intf #(.WIDTH(DW)) link ();

    // Downstream: either a hand-driven ack or a zero-delay receiver
    assign link.ack = autoAck ? (link.data != '0) : ackManual;

    sync_link_tx #(
        .REG_WIDTH      (REG_WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (link),
`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
        .ack_err  (ack_err),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Word to codeword by the rail rule: one -> 2, zero -> 1, per bit pair
    function automatic int encodeWord(input int w);
        int code;
        code = 0;
        for (int i = 0; i < REG_WIDTH; i++) begin
            code += (((w >> i) & 1) != 0 ? 2 : 1) * (4 ** i);
        end
        return code;
    endfunction

    // Codeword back to word; -1 for spacer pairs or the forbidden 2'b11
    function automatic int decodeWord(input logic [DW-1:0] d);
        int w;
        w = 0;
        for (int i = 0; i < REG_WIDTH; i++) begin
            if (d[2*i +: 2] == 2'b10) w += (1 << i);
            else if (d[2*i +: 2] != 2'b01) return -1;
        end
        return w;
    endfunction

    // Reference model: a token is either absent, shown as codeword, or
    // returning to spacer; the receiver's ack is seen SYNC_STAGES edges late
    int      mPhase;
    int      mWord;
    int      mCnt;
    logic    mErr;
    logic    mHist [SYNC_STAGES];
    logic    preAck;
    logic    preValid;
    logic [REG_WIDTH-1:0] preData;
    logic    mAckSeen;
    int      mNext;
    int      expQ [$];
    logic [DW-1:0] lastData = '0;

    initial begin
        preAck   = 1'b0;
        preValid = 1'b0;
        preData  = '0;
    end

    // Advance the model once per edge using values held just before the edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = 0;
            mWord  = 0;
            mCnt   = 0;
            mErr   = 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) mHist[k] = 1'b0;
        end else begin
            mAckSeen = mHist[SYNC_STAGES-1];
            mNext    = mPhase;
            if (mPhase == 0 && preValid && !mAckSeen) begin
                mNext = 1;
                mWord = int'(preData);
            end else if (mPhase == 1 && mAckSeen) begin
                mNext = 2;
            end else if (mPhase == 2 && !mAckSeen) begin
                mNext = 0;
            end
            if (mNext != mPhase || mNext == 0) mCnt = 0;
            else if (mCnt < TIMEOUT_CYCLES) mCnt++;
            if (mCnt == TIMEOUT_CYCLES) mErr = 1'b1;
            mPhase = mNext;
            for (int k = SYNC_STAGES - 1; k > 0; k--) mHist[k] = mHist[k-1];
            mHist[0] = preAck;
        end
    end

    // Compare every cycle on the falling edge; also keep word order
    always @(negedge clk) begin
        logic expReady;
        int   got;
        cycle++;
        expReady = (mPhase == 0) && !mHist[SYNC_STAGES-1];
        checkOutput("model data", 32'(link.data), (mPhase == 1) ? encodeWord(mWord) : 0);
        checkOutput("model busy", 32'(busy), 32'(mPhase != 0));
        checkOutput("model in_ready", 32'(in_ready), 32'(expReady));
`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
        checkOutput("model ack_err", 32'(ack_err), 32'(mErr));
`endif
        if (rst) begin
            expQ.delete();
        end else begin
            if (link.data != '0 && lastData == '0) begin
                got = decodeWord(link.data);
                if (expQ.size() == 0) checkOutput("unexpected token", 32'(got), 32'hFFFF_FFFF);
                else checkOutput("token order", 32'(got), 32'(expQ.pop_front()));
            end
            if (in_valid && expReady) expQ.push_back(int'(in_data));
        end
        lastData = link.data;
        preAck   = link.ack;
        preValid = in_valid;
        preData  = in_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [REG_WIDTH-1:0] w, input logic v);
        in_data  = w;
        in_valid = v;
    endtask

    task automatic waitReady(input int maxCycles, input string name);
        int n;
        n = 0;
        while (!in_ready && n < maxCycles) begin
            tick(1);
            n++;
        end
        if (!in_ready) checkOutput(name, 32'(in_ready), 32'd1);
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            tick(1);
            n++;
        end
        if (busy) checkOutput(name, 32'(busy), 32'd0);
    endtask

    logic [REG_WIDTH-1:0] b2bWords [3] = '{2'b00, 2'b11, 2'b01};
    logic [DW-1:0]        b2bCodes [3] = '{4'b0101, 4'b1010, 4'b0110};
    int                   acceptCycle [3];

    initial begin
        applyStimulus(2'b00, 1'b0);
        ackManual = 1'b0;
        autoAck   = 1'b0;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        checkOutput("reset data", 32'(link.data), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        checkOutput("ready after reset", 32'(in_ready), 32'd1);

        // Mid-cycle reset while idle
        rst = 1'b1;
        #1;
        checkOutput("midcycle reset data", 32'(link.data), 32'h0);
        checkOutput("midcycle reset busy", 32'(busy), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Single token with hand-driven ack
        applyStimulus(2'b10, 1'b1);
        tick(1);
        applyStimulus(2'b00, 1'b0);
        checkOutput("single codeword", 32'(link.data), 32'h9);
        checkOutput("single busy", 32'(busy), 32'd1);
        checkOutput("single not ready", 32'(in_ready), 32'd0);
        ackManual = 1'b1;
        tick(2);
        checkOutput("codeword held", 32'(link.data), 32'h9);
        tick(1);
        checkOutput("spacer 3 edges after ack", 32'(link.data), 32'h0);
        checkOutput("busy in null", 32'(busy), 32'd1);
        ackManual = 1'b0;
        tick(2);
        checkOutput("not ready yet", 32'(in_ready), 32'd0);
        tick(1);
        checkOutput("ready 3 edges after ack low", 32'(in_ready), 32'd1);
        checkOutput("idle busy", 32'(busy), 32'd0);

        // Back-to-back with a zero-delay receiver
        autoAck  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = b2bWords[i];
            waitReady(20, "b2b ready timeout");
            tick(1);
            acceptCycle[i] = cycle;
            checkOutput("b2b codeword", 32'(link.data), 32'(b2bCodes[i]));
            if (i > 0) checkOutput("b2b token period", 32'(acceptCycle[i] - acceptCycle[i-1]), 32'd7);
        end
        in_valid = 1'b0;
        waitIdle(20, "b2b idle timeout");
        autoAck = 1'b0;
        tick(1);

        // Stale ack high across reset release
        rst       = 1'b1;
        ackManual = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        checkOutput("stale ack not ready", 32'(in_ready), 32'd0);
        checkOutput("stale ack spacer", 32'(link.data), 32'h0);
        applyStimulus(2'b01, 1'b1);
        tick(2);
        checkOutput("no codeword over high ack", 32'(link.data), 32'h0);
        ackManual = 1'b0;
        tick(1);
        checkOutput("stale ack 1 edge", 32'(in_ready), 32'd0);
        tick(1);
        checkOutput("stale ack 2 edges ready", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
        checkOutput("after stale codeword", 32'(link.data), 32'h6);
        ackManual = 1'b1;
        tick(3);
        checkOutput("after stale spacer", 32'(link.data), 32'h0);
        ackManual = 1'b0;
        tick(3);
        checkOutput("after stale idle", 32'(busy), 32'd0);

        // Reset while a codeword is held
        applyStimulus(2'b10, 1'b1);
        tick(1);
        in_valid = 1'b0;
        checkOutput("eval codeword", 32'(link.data), 32'h9);
        rst = 1'b1;
        #1;
        checkOutput("eval reset data", 32'(link.data), 32'h0);
        checkOutput("eval reset busy", 32'(busy), 32'd0);
        tick(1);
        rst     = 1'b0;
        autoAck = 1'b1;
        applyStimulus(2'b11, 1'b1);
        waitReady(10, "post reset ready timeout");
        tick(1);
        in_valid = 1'b0;
        checkOutput("post reset codeword", 32'(link.data), 32'hA);
        waitIdle(20, "post reset idle timeout");
        autoAck = 1'b0;
        tick(1);

`ifdef SYNC_LINK_TX_ACK_TIMEOUT_EN
        // Withheld ack trips the sticky error without aborting the token
        ackManual = 1'b0;
        applyStimulus(2'b01, 1'b1);
        tick(1);
        in_valid = 1'b0;
        checkOutput("timeout err clear", 32'(ack_err), 32'd0);
        tick(15);
        checkOutput("timeout err at 15", 32'(ack_err), 32'd0);
        tick(1);
        checkOutput("timeout err at 16", 32'(ack_err), 32'd1);
        checkOutput("timeout still eval", 32'(link.data), 32'h6);
        ackManual = 1'b1;
        tick(3);
        checkOutput("late ack spacer", 32'(link.data), 32'h0);
        ackManual = 1'b0;
        tick(3);
        checkOutput("late ack idle", 32'(busy), 32'd0);
        checkOutput("err sticky", 32'(ack_err), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("err cleared by reset", 32'(ack_err), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
